// File: rtl/word_serializer.sv
// word_serializer
// Parallel-to-serial stage feeding the serial pattern detector. It accepts
// WIDTH-bit words over a valid/ready handshake and emits one bit per clock
// on x. Back-to-back words leave no gap in the bit stream.
//
// Parameters:
//   WIDTH     data word width (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//   IDLE_BIT  value driven on x while no bit is being sent
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    parallel word, sampled only on an accept cycle
//   in_valid   upstream holds a word on in_data
//   in_ready   block can take a word this cycle (combinational)
//   x          serial bit (registered)
//   bit_valid  x carries a data or parity bit (registered)
//   last_bit   x carries the final bit of the current word (registered)
//   busy       a word is in flight
//
// Optional feature: define WORD_SERIALIZER_PARITY_EN to append an even
// parity bit (^in_data) after the WIDTH data bits of every word.
module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] load_rest;
  logic             shift_bit;
  logic [WIDTH-1:0] shift_rest;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             parity;
`endif

  // The first bit goes straight to x at the accepting edge, so the shift
  // register only keeps the bits that are still to come.
  always_comb begin
    first_bit  = 1'b0;
    load_rest  = '0;
    shift_bit  = 1'b0;
    shift_rest = '0;
    if (MSB_FIRST) begin
      first_bit  = in_data[WIDTH-1];
      load_rest  = in_data << 1;
      shift_bit  = shreg[WIDTH-1];
      shift_rest = shreg << 1;
    end else begin
      first_bit  = in_data[0];
      load_rest  = in_data >> 1;
      shift_bit  = shreg[0];
      shift_rest = shreg >> 1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a word reloads from either IDLE or the last-bit
  // cycle of SHIFT; SHIFT drops to IDLE only when the last bit has gone
  // out with nothing new to take.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = SHIFT;
      SHIFT: if (cnt == '0 && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready = !rst && (state == IDLE || (state == SHIFT && cnt == '0));
    accept   = in_valid && in_ready;
    busy     = (state == SHIFT);
  end

  // Datapath: cnt counts bits still to be presented after the one on x,
  // so cnt==0 marks the last bit and is where a new word may be loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      x         <= IDLE_BIT;
      bit_valid <= 1'b0;
      last_bit  <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else if (accept) begin
      shreg     <= load_rest;
      cnt       <= CW'(NBITS - 1);
      x         <= first_bit;
      bit_valid <= 1'b1;
      last_bit  <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      parity    <= ^in_data;
`endif
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        x         <= IDLE_BIT;
        bit_valid <= 1'b0;
        last_bit  <= 1'b0;
      end else begin
        shreg     <= shift_rest;
        cnt       <= cnt - CW'(1);
        bit_valid <= 1'b1;
        last_bit  <= (cnt == CW'(1));
`ifdef WORD_SERIALIZER_PARITY_EN
        // cnt==1 here means the data bits are exhausted and the stored
        // parity bit is the one to present.
        x         <= (cnt == CW'(1)) ? parity : shift_bit;
`else
        x         <= shift_bit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
// Self-checking bench for word_serializer. Two instances (MSB-first and
// LSB-first) receive the same stimulus. A queue-based model holds the bits
// each instance still has to show; every cycle the outputs are compared
// against the head of that queue. Hand-computed literal words captured from
// x pin the model. Honours WORD_SERIALIZER_PARITY_EN.
module tb_word_serializer;

  localparam int W      = 8;
  localparam bit IDLE_B = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         rdy_m, x_m, bv_m, lb_m, busy_m;
  logic         rdy_l, x_l, bv_l, lb_l, busy_l;

  int vectors;
  int miscompares;
  bit chk_en;
  bit q_m[$];
  bit q_l[$];
  bit mdl_ready;
  logic [31:0] cap_m;
  logic [31:0] cap_l;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_B)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .x(x_m), .bit_valid(bv_m), .last_bit(lb_m), .busy(busy_m)
  );

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_B)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .x(x_l), .bit_valid(bv_l), .last_bit(lb_l), .busy(busy_l)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each queue holds the bit currently on x followed by the bits
  // still to come. A word is taken when nothing or only the last bit is
  // showing.
  always @(posedge clk) begin
    if (rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      mdl_ready = (q_m.size() <= 1);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (in_valid && mdl_ready) begin
        for (int k = 0; k < W; k++) begin
          q_m.push_back(in_data[W-1-k]);
          q_l.push_back(in_data[k]);
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        q_m.push_back(^in_data);
        q_l.push_back(^in_data);
`endif
      end
    end
  end

  task automatic check_output(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus capture of emitted bits
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("msb.in_ready",  rdy_m,  !rst && q_m.size() <= 1);
      check_output("msb.x",         x_m,    q_m.size() > 0 ? q_m[0] : IDLE_B);
      check_output("msb.bit_valid", bv_m,   q_m.size() > 0);
      check_output("msb.last_bit",  lb_m,   q_m.size() == 1);
      check_output("msb.busy",      busy_m, q_m.size() > 0);
      check_output("lsb.in_ready",  rdy_l,  !rst && q_l.size() <= 1);
      check_output("lsb.x",         x_l,    q_l.size() > 0 ? q_l[0] : IDLE_B);
      check_output("lsb.bit_valid", bv_l,   q_l.size() > 0);
      check_output("lsb.last_bit",  lb_l,   q_l.size() == 1);
      check_output("lsb.busy",      busy_l, q_l.size() > 0);
      if (bv_m === 1'b1) cap_m = {cap_m[30:0], x_m};
      if (bv_l === 1'b1) cap_l = {cap_l[30:0], x_l};
    end
  end

  // Present one word for a single edge while the block is idle, then let
  // it drain; in_data is scrambled afterwards since it must be ignored.
  task automatic apply_stimulus(input logic [W-1:0] d);
    cap_m    = '0;
    cap_l    = '0;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    repeat (NB + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    cap_m       = '0;
    cap_l       = '0;

    // Reset held for three edges with in_valid asserted
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("reset.in_ready", rdy_m, 1'b0);
    check_output("reset.x", x_m, 1'b0);
    check_output("reset.busy", busy_m, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single word A3 on both bit orders
    apply_stimulus(8'hA3);
`ifdef WORD_SERIALIZER_PARITY_EN
    check_word("word_a3.msb", cap_m, 32'b101000110);
    check_word("word_a3.lsb", cap_l, 32'b110001010);
`else
    check_word("word_a3.msb", cap_m, 32'hA3);
    check_word("word_a3.lsb", cap_l, 32'hC5);
`endif

    // Back-to-back F0 then 0F with in_valid held high
    cap_m    = '0;
    cap_l    = '0;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(posedge clk);
    #1;
    in_data = 8'h0F;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rdy_m === 1'b1) found = 1'b1;
    end
    check_output("b2b.ready_seen", found, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (NB + 1) @(posedge clk);
    #1;
`ifdef WORD_SERIALIZER_PARITY_EN
    check_word("b2b.msb", cap_m, 32'b111100000000011110);
    check_word("b2b.lsb", cap_l, 32'b000011110111100000);
`else
    check_word("b2b.msb", cap_m, 32'hF00F);
    check_word("b2b.lsb", cap_l, 32'h0FF0);
`endif

    // Reset after three bits of FF
    cap_m    = '0;
    cap_l    = '0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst.x", x_m, 1'b0);
    check_output("midrst.bit_valid", bv_m, 1'b0);
    check_output("midrst.busy", busy_m, 1'b0);
    check_output("midrst.in_ready", rdy_m, 1'b1);
    check_word("midrst.bits", cap_m, 32'h7);
    @(posedge clk);
    #1;
    apply_stimulus(8'h01);
`ifdef WORD_SERIALIZER_PARITY_EN
    check_word("after_rst.msb", cap_m, 32'b000000011);
    check_word("after_rst.lsb", cap_l, 32'b100000001);
`else
    check_word("after_rst.msb", cap_m, 32'h01);
    check_word("after_rst.lsb", cap_l, 32'h80);
`endif

    // Word with an odd number of ones
    apply_stimulus(8'h07);
`ifdef WORD_SERIALIZER_PARITY_EN
    check_word("word_07.msb", cap_m, 32'b000001111);
    check_word("word_07.lsb", cap_l, 32'b111000001);
`else
    check_word("word_07.msb", cap_m, 32'h07);
    check_word("word_07.lsb", cap_l, 32'hE0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
